// File: rtl/rd_line_buffer_pkg.sv
// Shared video definitions for the real-resolution line buffer: line length,
// RGB565/RGB888 field widths, default fill colours and the 565->888 expansion.
package rd_line_buffer_pkg;

  localparam int RD_H_DEF = 480;

  localparam int R5_W     = 5;
  localparam int G6_W     = 6;
  localparam int B5_W     = 5;
  localparam int RGB565_W = 16;
  localparam int RGB888_W = 24;

  localparam logic [RGB888_W-1:0] BORDER_RGB_DEF   = 24'h000000;
  localparam logic [RGB888_W-1:0] UNDERRUN_RGB_DEF = 24'hFF00FF;

  // Where the pixel of a given input cycle comes from.
  typedef enum logic [1:0] {
    PIX_ZERO     = 2'd0,
    PIX_BORDER   = 2'd1,
    PIX_UNDERRUN = 2'd2,
    PIX_RAM      = 2'd3
  } pix_src_e;

  // Expand RGB565 to RGB888 by replicating the top bits into the low bits,
  // so full-scale 5/6-bit values map to 8'hFF.
  function automatic logic [RGB888_W-1:0] rgb565_to_888(input logic [RGB565_W-1:0] px);
    logic [R5_W-1:0] r5;
    logic [G6_W-1:0] g6;
    logic [B5_W-1:0] b5;
    r5 = px[15:11];
    g6 = px[10:5];
    b5 = px[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/rd_line_buffer_line_bank_ram.sv
// One line bank: simple dual-port RAM, one write port and one read port
// with one cycle of synchronous read latency. Contents are not reset.
module line_bank_ram
  import rd_line_buffer_pkg::*;
#(
  parameter int DEPTH = RD_H_DEF,
  parameter int AW    = $clog2(RD_H_DEF)
)(
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [RGB565_W-1:0] wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [RGB565_W-1:0] rdata
);

  logic [RGB565_W-1:0] mem_r [DEPTH];
  logic [RGB565_W-1:0] rdata_r;

  // Write port: store the accepted pixel.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: registered read, only when a read is requested.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/rd_line_buffer.sv
// Ping-pong line buffer: a pixel source fills two line banks in RGB565, the
// video side reads one line per rd_in window and emits RGB888 aligned with the
// timing signals two cycles later. Underrun and over-long windows get fill colours.
module rd_line_buffer
  import rd_line_buffer_pkg::*;
#(
  parameter int                   RD_H         = RD_H_DEF,
  parameter logic [RGB888_W-1:0]  BORDER_RGB   = BORDER_RGB_DEF,
  parameter logic [RGB888_W-1:0]  UNDERRUN_RGB = UNDERRUN_RGB_DEF
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic                de_in,
  input  logic                rd_in,
  input  logic [RGB565_W-1:0] wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic                line_req,
  output logic [RGB888_W-1:0] rgb_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                de_out,
  output logic                underrun
);

  localparam int AW = (RD_H > 1) ? $clog2(RD_H) : 1;
  // Read pointer must be able to hold RD_H itself (window exhausted).
  localparam int PW = $clog2(RD_H + 1);
  localparam logic [PW-1:0] RD_END  = PW'(RD_H);
  localparam logic [AW-1:0] WR_LAST = AW'(RD_H - 1);

  logic [1:0]          full_r, full_nxt_s;
  logic                wsel_r, wsel_nxt_s;
  logic                rsel_r, rsel_nxt_s;
  logic [AW-1:0]       wr_ptr_r, wr_ptr_nxt_s;
  logic [PW-1:0]       rd_ptr_r, rd_ptr_nxt_s;
  logic                underrun_r, underrun_nxt_s;
  logic                line_req_r, line_req_nxt_s;
  logic                prefill2_r, prefill2_nxt_s;
  logic                wr_ready_r, wr_ready_nxt_s;
  logic                rd_prev_r, vs_prev_r;

  logic                vs_rise_s, rd_fall_s, wr_acc_s, rd_hit_s;
  logic                we0_s, we1_s, re0_s, re1_s;
  logic [RGB565_W-1:0] rdata0_s, rdata1_s;
  pix_src_e            src_s, src_d1_r;
  logic                bank_d1_r, hs_d1_r, vs_d1_r, de_d1_r;
  logic [RGB888_W-1:0] rgb_s, rgb_r;
  logic                hs_r, vs_r, de_r;

  // Edge detection, handshake and classification of this cycle's pixel.
  always_comb begin
    vs_rise_s = vs_in & ~vs_prev_r;
    rd_fall_s = rd_prev_r & ~rd_in;
    wr_acc_s  = wr_valid & wr_ready_r;
    rd_hit_s  = rd_in & full_r[rsel_r] & (rd_ptr_r != RD_END);
    src_s     = PIX_ZERO;
    if (!de_in) begin
      src_s = PIX_ZERO;
    end else if (!rd_in) begin
      src_s = PIX_BORDER;
    end else if (!full_r[rsel_r]) begin
      src_s = PIX_UNDERRUN;
    end else if (rd_ptr_r == RD_END) begin
      src_s = PIX_BORDER;
    end else begin
      src_s = PIX_RAM;
    end
  end

  // Next state of the bank bookkeeping; frame start overrides everything.
  always_comb begin
    full_nxt_s     = full_r;
    wsel_nxt_s     = wsel_r;
    rsel_nxt_s     = rsel_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    underrun_nxt_s = underrun_r;
    line_req_nxt_s = 1'b0;
    prefill2_nxt_s = 1'b0;
    if (vs_rise_s) begin
      full_nxt_s     = 2'b00;
      wsel_nxt_s     = 1'b0;
      rsel_nxt_s     = 1'b0;
      wr_ptr_nxt_s   = '0;
      rd_ptr_nxt_s   = '0;
      underrun_nxt_s = 1'b0;
      line_req_nxt_s = 1'b1;
      prefill2_nxt_s = 1'b1;
    end else begin
      line_req_nxt_s = prefill2_r;
      // Writer: the last pixel of a line marks the bank full and flips banks.
      if (wr_acc_s) begin
        if (wr_ptr_r == WR_LAST) begin
          full_nxt_s[wsel_r] = 1'b1;
          wsel_nxt_s         = ~wsel_r;
          wr_ptr_nxt_s       = '0;
        end else begin
          wr_ptr_nxt_s = wr_ptr_r + AW'(1'b1);
        end
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (rd_hit_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PW'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (rd_in && !full_r[rsel_r]) begin
        underrun_nxt_s = 1'b1;
      end else begin
        underrun_nxt_s = underrun_r;
      end
      // Reader: any window that consumed pixels releases its bank at the end.
      if (rd_fall_s && (rd_ptr_r != '0)) begin
        full_nxt_s[rsel_r] = 1'b0;
        rsel_nxt_s         = ~rsel_r;
        rd_ptr_nxt_s       = '0;
        line_req_nxt_s     = 1'b1;
      end else begin
        rsel_nxt_s = rsel_r;
      end
    end
    wr_ready_nxt_s = ~full_nxt_s[wsel_nxt_s];
  end

  // Bank bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r     <= 2'b00;
      wsel_r     <= 1'b0;
      rsel_r     <= 1'b0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      underrun_r <= 1'b0;
      line_req_r <= 1'b0;
      prefill2_r <= 1'b0;
      wr_ready_r <= 1'b1;
      rd_prev_r  <= 1'b0;
      vs_prev_r  <= 1'b0;
    end else begin
      full_r     <= full_nxt_s;
      wsel_r     <= wsel_nxt_s;
      rsel_r     <= rsel_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      underrun_r <= underrun_nxt_s;
      line_req_r <= line_req_nxt_s;
      prefill2_r <= prefill2_nxt_s;
      wr_ready_r <= wr_ready_nxt_s;
      rd_prev_r  <= rd_in;
      vs_prev_r  <= vs_in;
    end
  end

  // Per-bank RAM strobes; a write in the frame-start cycle is dropped.
  always_comb begin
    we0_s = wr_acc_s & ~vs_rise_s & ~wsel_r;
    we1_s = wr_acc_s & ~vs_rise_s &  wsel_r;
    re0_s = rd_hit_s & ~rsel_r;
    re1_s = rd_hit_s &  rsel_r;
  end

  line_bank_ram #(.DEPTH(RD_H), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (we0_s),
    .waddr (wr_ptr_r),
    .wdata (wr_data),
    .re    (re0_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rdata0_s)
  );

  line_bank_ram #(.DEPTH(RD_H), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (we1_s),
    .waddr (wr_ptr_r),
    .wdata (wr_data),
    .re    (re1_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rdata1_s)
  );

  // Stage 1: carry timing and pixel source alongside the RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_d1_r  <= PIX_ZERO;
      bank_d1_r <= 1'b0;
      hs_d1_r   <= 1'b0;
      vs_d1_r   <= 1'b0;
      de_d1_r   <= 1'b0;
    end else begin
      src_d1_r  <= src_s;
      bank_d1_r <= rsel_r;
      hs_d1_r   <= hs_in;
      vs_d1_r   <= vs_in;
      de_d1_r   <= de_in;
    end
  end

  // Pick the final colour once the RAM data is available.
  always_comb begin
    rgb_s = '0;
    case (src_d1_r)
      PIX_ZERO:     rgb_s = '0;
      PIX_BORDER:   rgb_s = BORDER_RGB;
      PIX_UNDERRUN: rgb_s = UNDERRUN_RGB;
      PIX_RAM:      rgb_s = rgb565_to_888(bank_d1_r ? rdata1_s : rdata0_s);
      default:      rgb_s = '0;
    endcase
  end

  // Stage 2: output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_r <= '0;
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      de_r  <= 1'b0;
    end else begin
      rgb_r <= rgb_s;
      hs_r  <= hs_d1_r;
      vs_r  <= vs_d1_r;
      de_r  <= de_d1_r;
    end
  end

  assign rgb_out  = rgb_r;
  assign hs_out   = hs_r;
  assign vs_out   = vs_r;
  assign de_out   = de_r;
  assign line_req = line_req_r;
  assign underrun = underrun_r;
  assign wr_ready = wr_ready_r;

endmodule

// File: doc/rd_line_buffer.md
RD_LINE_BUFFER -- requirements
Module: rd_line_buffer

Interface
REQ-001 Parameter RD_H, default 480, pixels per real-resolution line.
REQ-002 Parameter BORDER_RGB, default 24'h000000, colour for de pixels outside the rd window.
REQ-003 Parameter UNDERRUN_RGB, default 24'hFF00FF, colour for rd pixels with no line loaded.
REQ-004 clk  input  1  pixel clock; reset rst, asynchronous, active-high; clock clk.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 hs_in, vs_in, de_in  input  1 each  sync/valid from timing generator.
REQ-007 rd_in  input  1  real-resolution window strobe, high for RD_H consecutive cycles per active line.
REQ-008 wr_data  input  16  RGB565 pixel, {r[4:0], g[5:0], b[4:0]}.
REQ-009 wr_valid  input  1; wr_ready  output  1  write handshake.
REQ-010 line_req  output  1  one-cycle pulse requesting the next line from the pixel source.
REQ-011 rgb_out  output  24; hs_out, vs_out, de_out  output  1 each  aligned video out.
REQ-012 underrun  output  1  sticky underrun flag.

Function
REQ-013 Storage: two banks of RD_H x 16 bits, each with a full flag; write-bank select wsel, read-bank select rsel.
REQ-014 wr_ready = ~full[wsel]; write accepted on wr_valid & wr_ready.
REQ-015 Accepted write stores at bank wsel, address wr_ptr, then increments wr_ptr.
REQ-016 Write at wr_ptr == RD_H-1: set full[wsel], toggle wsel, wr_ptr = 0 in the same cycle.
REQ-017 Each rd_in-high cycle with full[rsel] and rd_ptr < RD_H reads bank rsel at rd_ptr, then increments rd_ptr.
REQ-018 rd_in high with rd_ptr == RD_H (over-long window): no read, pixel = BORDER_RGB, rd_ptr holds.
REQ-019 rd_in high with full[rsel] == 0: pixel = UNDERRUN_RGB, underrun set, rd_ptr unchanged.
REQ-020 rd_in falling edge with rd_ptr == RD_H: clear full[rsel], toggle rsel, rd_ptr = 0, line_req pulses next cycle.
REQ-021 rd_in falling edge with 0 < rd_ptr < RD_H (short window): bank still released as in REQ-020.
REQ-022 Write fill (REQ-016) and read release (REQ-020) in the same cycle both take effect; full flags of different banks update independently.
REQ-023 vs_in rising edge: full[1:0] = 0, wsel = rsel = 0, wr_ptr = rd_ptr = 0, underrun = 0; line_req pulses twice, on the next cycle and the cycle after, to prefill both banks; a write in this cycle is discarded.
REQ-024 Colour expansion: r8 = {r5, r5[4:2]}, g8 = {g6, g6[5:4]}, b8 = {b5, b5[4:2]}; rgb_out = {r8, g8, b8}.
REQ-025 Latency: hs_out, vs_out and de_out equal hs_in, vs_in and de_in delayed exactly 2 cycles; rgb_out is the pixel for the input cycle 2 cycles earlier.
REQ-026 de_out high with that cycle's rd_in low: rgb_out = BORDER_RGB; de_out low: rgb_out = 0.
REQ-027 RAM read uses 1-cycle synchronous latency plus 1 output register stage.

Reset
REQ-028 On rst: rgb_out = 0, hs_out = vs_out = de_out = 0, line_req = 0, underrun = 0, wr_ready = 1.
REQ-029 On rst: full = 0, wsel = rsel = 0, pointers = 0, delay pipelines = 0; RAM contents need not be cleared.
REQ-030 rst asserted mid-line aborts all transfers; the first line_req after release comes only from REQ-023.

Structure
REQ-031 Shared video package holds RD_H, the RGB565/RGB888 field widths and the default BORDER_RGB and UNDERRUN_RGB constants.
REQ-032 Sub-module line_bank_ram: simple dual-port RAM, RD_H x 16, synchronous read; instantiated twice.

Verification
REQ-033 Reset, then vs_in pulse -> line_req pulses 2 cycles; write 2 x 480 pixels -> wr_ready low after pixel 960.
REQ-034 Bank 0 loaded with 0xF800; 480-cycle rd_in -> rgb_out = 24'hFF0000 for 480 cycles starting 2 cycles after rd_in rises; bank released; line_req pulses.
REQ-035 rd_in window with no bank loaded -> rgb_out = 24'hFF00FF, underrun = 1 until the next vs_in rising edge.
REQ-036 de_in high with rd_in low -> rgb_out = 24'h000000; hs_in/vs_in/de_in edges appear on the outputs exactly 2 cycles later.
REQ-037 481-cycle rd_in -> last pixel = BORDER_RGB, bank released once; writer completes a line in the same cycle as a release -> both full flags correct.
REQ-038 rst asserted at pixel 200 of a line -> outputs at reset values; after release, no read occurs until refill completes.
